// File: rtl/tcm_arb_pkg.sv
// Shared types and constants for the AXI-to-TCM port arbiter.
package tcm_arb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrIssue,
    StBResp,
    StRdIssue,
    StRdData,
    StRResp
  } tcm_state_e;

  typedef enum logic {
    GNT_WR,
    GNT_RD
  } grant_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;

endpackage

// File: rtl/tcm_arb_rr2.sv
// Two-way write/read arbiter: fixed write priority or alternating on conflict.
module tcm_arb_rr2
  import tcm_arb_pkg::*;
#(
  parameter int unsigned ARB_MODE = ARB_FIXED
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic wr_req_i,
  input  logic rd_req_i,
  output logic gnt_wr_o,
  output logic gnt_rd_o
);

  grant_e last_grant_q;

  always_comb begin
    gnt_wr_o = 1'b0;
    gnt_rd_o = 1'b0;
    if (en_i) begin
      if (wr_req_i && rd_req_i) begin
        // Round-robin hands a conflict to whichever side did not win last.
        if (ARB_MODE == ARB_RR && last_grant_q == GNT_WR) begin
          gnt_rd_o = 1'b1;
        end else begin
          gnt_wr_o = 1'b1;
        end
      end else begin
        gnt_wr_o = wr_req_i;
        gnt_rd_o = rd_req_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant_q <= GNT_RD;
    end else if (gnt_wr_o) begin
      last_grant_q <= GNT_WR;
    end else if (gnt_rd_o) begin
      last_grant_q <= GNT_RD;
    end
  end

endmodule

// File: rtl/tcm_axi_port_arb.sv
// Single-outstanding AXI write/read port multiplexed onto one single-ported TCM,
// with out-of-range SLVERR responses and strobes held quiet while in reset.
module tcm_axi_port_arb
  import tcm_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MEM_AW   = 16,
  parameter int unsigned ARB_MODE = ARB_FIXED
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  axi_awvalid_i,
  input  logic [ADDR_W-1:0]     axi_awaddr_i,
  input  logic                  axi_wvalid_i,
  input  logic [DATA_W-1:0]     axi_wdata_i,
  input  logic [DATA_W/8-1:0]   axi_wstrb_i,
  output logic                  axi_awready_o,
  output logic                  axi_wready_o,
  output logic                  axi_bvalid_o,
  output logic [1:0]            axi_bresp_o,
  input  logic                  axi_bready_i,
  input  logic                  axi_arvalid_i,
  input  logic [ADDR_W-1:0]     axi_araddr_i,
  output logic                  axi_arready_o,
  output logic                  axi_rvalid_o,
  output logic [DATA_W-1:0]     axi_rdata_o,
  output logic [1:0]            axi_rresp_o,
  input  logic                  axi_rready_i,
  output logic [MEM_AW-1:0]     mem_addr_o,
  output logic [DATA_W/8-1:0]   mem_wr_o,
  output logic                  mem_rd_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  input  logic [DATA_W-1:0]     mem_rdata_i
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);
  localparam logic [MEM_AW-1:0] AlignMask = {{(MEM_AW - OFF_W){1'b1}}, {OFF_W{1'b0}}};

  function automatic logic [MEM_AW-1:0] align_addr(input logic [ADDR_W-1:0] a);
    return a[MEM_AW-1:0] & AlignMask;
  endfunction

  function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:MEM_AW] != '0;
  endfunction

  tcm_state_e          state_q;
  logic                req_wr_q, req_rd_q;
  logic [MEM_AW-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   strb_q;
  logic                oor_q;
  logic                bvalid_q, rvalid_q;
  logic [1:0]          bresp_q, rresp_q;
  logic [DATA_W-1:0]   rdata_q;

  logic wr_cand, rd_cand, arb_en, gnt_wr, gnt_rd;

  assign wr_cand = axi_awvalid_i & axi_wvalid_i;
  assign rd_cand = axi_arvalid_i;
  assign arb_en  = (state_q == StIdle) && !rst_i;

  tcm_arb_rr2 #(
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (arb_en),
    .wr_req_i (wr_cand),
    .rd_req_i (rd_cand),
    .gnt_wr_o (gnt_wr),
    .gnt_rd_o (gnt_rd)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      req_wr_q <= 1'b0;
      req_rd_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      strb_q   <= '0;
      oor_q    <= 1'b0;
      bvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (gnt_wr) begin
            addr_q   <= align_addr(axi_awaddr_i);
            wdata_q  <= axi_wdata_i;
            strb_q   <= axi_wstrb_i;
            oor_q    <= out_of_range(axi_awaddr_i);
            req_wr_q <= 1'b1;
            state_q  <= StWrIssue;
          end else if (gnt_rd) begin
            addr_q   <= align_addr(axi_araddr_i);
            oor_q    <= out_of_range(axi_araddr_i);
            req_rd_q <= 1'b1;
            state_q  <= StRdIssue;
          end
        end
        StWrIssue: begin
          req_wr_q <= 1'b0;
          bvalid_q <= 1'b1;
          bresp_q  <= oor_q ? RESP_SLVERR : RESP_OKAY;
          state_q  <= StBResp;
        end
        StBResp: begin
          if (axi_bready_i) begin
            bvalid_q <= 1'b0;
            state_q  <= StIdle;
          end
        end
        StRdIssue: begin
          req_rd_q <= 1'b0;
          state_q  <= StRdData;
        end
        StRdData: begin
          // TCM data lands exactly one cycle after the read strobe.
          rdata_q  <= oor_q ? '0 : mem_rdata_i;
          rresp_q  <= oor_q ? RESP_SLVERR : RESP_OKAY;
          rvalid_q <= 1'b1;
          state_q  <= StRResp;
        end
        StRResp: begin
          if (axi_rready_i) begin
            rvalid_q <= 1'b0;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    if (req_wr_q || req_rd_q) begin
      mem_addr_o = addr_q;
    end else if (wr_cand) begin
      mem_addr_o = align_addr(axi_awaddr_i);
    end else begin
      mem_addr_o = align_addr(axi_araddr_i);
    end
  end

  // Strobes are gated by rst_i so nothing reaches the RAM during reset.
  assign mem_wr_o    = (state_q == StWrIssue && !oor_q && !rst_i) ? strb_q : '0;
  assign mem_rd_o    = (state_q == StRdIssue) && !oor_q && !rst_i;
  assign mem_wdata_o = wdata_q;

  assign axi_awready_o = gnt_wr;
  assign axi_wready_o  = gnt_wr;
  assign axi_arready_o = gnt_rd;
  assign axi_bvalid_o  = bvalid_q;
  assign axi_bresp_o   = bresp_q;
  assign axi_rvalid_o  = rvalid_q;
  assign axi_rresp_o   = rresp_q;
  assign axi_rdata_o   = rdata_q;

endmodule
